// File: rtl/int_wb_queue.sv
// Int Pipe -> Writeback receive queue.
// In-order FIFO of integer-pipe results, drained to the register-file
// write port through a valid/ready handshake. Scalar results are
// normalised to lane 0 at push. int_stall asserts early enough to absorb
// the one result still in flight when the Int Pipe enable drops.

package int_wb_queue_pkg;
    localparam int HW_LANE = 16;

    typedef logic [31:0]              register_t;
    typedef register_t [HW_LANE-1:0]  hw_lane_t;
    typedef logic [HW_LANE-1:0]       hw_lane_mask_t;
    typedef logic [2:0]               thread_id_t;
    typedef logic [5:0]               reg_addr_t;

    typedef struct packed {
        register_t  pc;
        thread_id_t thread_id;
        reg_addr_t  destination;
        logic       is_destination_vectorial;
    } instruction_decoded_t;

    typedef struct packed {
        thread_id_t    thread_id;
        reg_addr_t     destination;
        logic          is_vectorial;
        hw_lane_t      result;
        hw_lane_mask_t mask;
        register_t     pc;
    } wb_entry_t;
endpackage

module int_wb_queue
    import int_wb_queue_pkg::*;
#(
    parameter int DEPTH           = 4,
    parameter int STALL_THRESHOLD = DEPTH - 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       int_valid,
    input  instruction_decoded_t       int_inst_scheduled,
    input  hw_lane_t                   int_result,
    input  hw_lane_mask_t              int_hw_lane_mask,
    output logic                       int_stall,
    output logic                       wb_valid,
    input  logic                       wb_ready,
    output thread_id_t                 wb_thread_id,
    output reg_addr_t                  wb_destination,
    output logic                       wb_is_vectorial,
    output hw_lane_t                   wb_result,
    output hw_lane_mask_t              wb_hw_lane_mask,
    output register_t                  wb_pc,
    output logic [$clog2(DEPTH):0]     occupancy,
    output logic                       overflow
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;

    wb_entry_t         mem_q [DEPTH];
    wb_entry_t         mem_d [DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [OCC_W-1:0]  occupancy_q, occupancy_d;
    logic              overflow_q, overflow_d;

    wb_entry_t         new_entry;
    wb_entry_t         head;
    logic              full;
    logic              pop;
    logic              push;

    // Build the entry to store, folding scalar results down to lane 0.
    always_comb begin
        new_entry.thread_id    = int_inst_scheduled.thread_id;
        new_entry.destination  = int_inst_scheduled.destination;
        new_entry.is_vectorial = int_inst_scheduled.is_destination_vectorial;
        new_entry.result       = int_result;
        new_entry.mask         = int_hw_lane_mask;
        new_entry.pc           = int_inst_scheduled.pc;
        if (!int_inst_scheduled.is_destination_vectorial) begin
            new_entry.result    = '0;
            new_entry.result[0] = int_result[0];
            new_entry.mask      = HW_LANE'(1);
        end
    end

    // Handshake decode; a full queue still accepts a push if the head leaves.
    always_comb begin
        full = (occupancy_q == OCC_W'(DEPTH));
        pop  = (occupancy_q != '0) && wb_ready;
        push = int_valid && (!full || pop);
    end

    // Next-state for storage, pointers, occupancy and the sticky overflow flag.
    always_comb begin
        mem_d       = mem_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        occupancy_d = occupancy_q;
        overflow_d  = overflow_q;
        if (push) begin
            mem_d[wr_ptr_q] = new_entry;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push && !pop) begin
            occupancy_d = occupancy_q + OCC_W'(1);
        end else if (pop && !push) begin
            occupancy_d = occupancy_q - OCC_W'(1);
        end
        if (int_valid && full && !pop) begin
            overflow_d = 1'b1;
        end
    end

    // State registers; storage is cleared too so the head reads zero after reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            occupancy_q <= '0;
            overflow_q  <= 1'b0;
        end else begin
            mem_q       <= mem_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            occupancy_q <= occupancy_d;
            overflow_q  <= overflow_d;
        end
    end

    // Head fields are read straight from storage; no push-to-output bypass.
    always_comb begin
        head            = mem_q[rd_ptr_q];
        wb_valid        = (occupancy_q != '0);
        wb_thread_id    = head.thread_id;
        wb_destination  = head.destination;
        wb_is_vectorial = head.is_vectorial;
        wb_result       = head.result;
        wb_hw_lane_mask = head.mask;
        wb_pc           = head.pc;
        occupancy       = occupancy_q;
        overflow        = overflow_q;
        int_stall       = (occupancy_q >= OCC_W'(STALL_THRESHOLD));
    end

`ifndef SYNTHESIS
    // Flag the first dropped result so it is visible in simulation logs.
    always @(posedge clk) begin
        if (reset) begin
            assert (!(overflow_d && !overflow_q))
                else $warning("int_wb_queue: queue full, result dropped");
        end
    end
`endif

endmodule
